sram_like_ram_bridge: RTL

//  Bridges one CPU-side sram-like port (req/addr_ok/data_ok) onto one word-wide

---
 rtl/sram_like_ram_bridge_if.sv | 16 +
 rtl/sram_like_ram_bridge.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sram_like_ram_bridge_if.sv
// CPU-side sram-like handshake bundle: req/addr_ok request phase and data_ok response phase.
interface sram_like_ram_bridge_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic                    wr;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic [31:0]             addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    addr_ok;
  logic                    data_ok;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, wr, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_ram_bridge.sv
// Sram-like CPU port to word-wide async-read RAM bridge with programmable access
// delay. Partial-strobe writes become a read-modify-write because the RAM only has
// a whole-word write enable.
module sram_like_ram_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DELAY      = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  sram_like_ram_bridge_if.slave  cpu,
  output logic                   ram_we,
  output logic [ADDR_WIDTH-1:0]  ram_a,
  output logic [DATA_WIDTH-1:0]  ram_d,
  input  logic [DATA_WIDTH-1:0]  ram_spo
);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [7:0] CNT_INIT = (DELAY > 0) ? 8'(DELAY - 1) : 8'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_WRITE, S_RESP} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, old_q, rdata_q;
  logic [SW-1:0]         wstrb_q;
  logic                  wr_q;
  logic [7:0]            cnt_q;
  logic                  addr_ok_q, data_ok_q, ram_we_q;
  logic [DATA_WIDTH-1:0] merged;
  logic                  wstrb_full, wstrb_none;

  // Byte-select and word-offset address bits never reach the RAM.
  logic unused_addr;
  assign unused_addr = ^{cpu.addr[31:ADDR_WIDTH+2], cpu.addr[1:0]};

  assign wstrb_full = &wstrb_q;
  assign wstrb_none = ~|wstrb_q;

  // Byte merge of new write data over the word read back in ACCESS. With all
  // strobes set this is just wdata_q, so it also serves the full-word write.
  for (genvar i = 0; i < SW; i++) begin : g_byte
    assign merged[i*8 +: 8] = wstrb_q[i] ? wdata_q[i*8 +: 8] : old_q[i*8 +: 8];
  end

  assign ram_a       = addr_q;
  assign ram_d       = merged;
  assign ram_we      = ram_we_q;
  assign cpu.addr_ok = addr_ok_q;
  assign cpu.data_ok = data_ok_q;
  assign cpu.rdata   = rdata_q;

  // Request FSM; addr_ok/data_ok/ram_we are registered from the transition taken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wr_q      <= 1'b0;
      old_q     <= '0;
      rdata_q   <= '0;
      cnt_q     <= 8'd0;
      addr_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      ram_we_q  <= 1'b0;
    end else begin
      ram_we_q  <= 1'b0;
      data_ok_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu.req && addr_ok_q) begin
            addr_q    <= cpu.addr[ADDR_WIDTH+1:2];
            wdata_q   <= cpu.wdata;
            wstrb_q   <= cpu.wstrb;
            wr_q      <= cpu.wr;
            addr_ok_q <= 1'b0;
            if (DELAY > 0) begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end else begin
              state_q  <= S_ACCESS;
              ram_we_q <= cpu.wr & (&cpu.wstrb);
            end
          end else begin
            // Also raises addr_ok on the first cycle after reset release.
            addr_ok_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q == 8'd0) begin
            state_q  <= S_ACCESS;
            ram_we_q <= wr_q & wstrb_full;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_ACCESS: begin
          if (!wr_q) begin
            rdata_q   <= ram_spo;
            state_q   <= S_RESP;
            data_ok_q <= 1'b1;
          end else if (wstrb_full || wstrb_none) begin
            state_q   <= S_RESP;
            data_ok_q <= 1'b1;
          end else begin
            old_q    <= ram_spo;
            state_q  <= S_WRITE;
            ram_we_q <= 1'b1;
          end
        end
        S_WRITE: begin
          state_q   <= S_RESP;
          data_ok_q <= 1'b1;
        end
        S_RESP: begin
          state_q   <= S_IDLE;
          addr_ok_q <= 1'b1;
        end
        default: begin
          state_q   <= S_IDLE;
          addr_ok_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
